// File: rtl/w_shift_pkg.sv
// Shared types and constants for the W'/W digit shifter and its LCD scanner.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// Contents:
//   w_cmd_t      - W-family command encoding driven by the instruction decoder
//   scan_state_t - digit scanner FSM states
//   W_PLA_DATA   - 32x4 SM5a segment PLA table (only with W_SHIFT_PLA_EN)
//   pla_lookup   - PLA digit including the m' OR-in (only with W_SHIFT_PLA_EN)
package w_shift_pkg;

    typedef enum logic [2:0] {
        CMD_NOP  = 3'd0,
        CMD_WR   = 3'd1,
        CMD_WS   = 3'd2,
        CMD_DTW  = 3'd3,
        CMD_PDTW = 3'd4,
        CMD_PTW  = 3'd5,
        CMD_TW   = 3'd6,
        CMD_CLR  = 3'd7
    } w_cmd_t;

    typedef enum logic [1:0] {
        SCAN_IDLE = 2'd0,
        SCAN_RUN  = 2'd1,
        SCAN_DONE = 2'd2
    } scan_state_t;

`ifdef W_SHIFT_PLA_EN
    // Index is {lcd_cn, acc}; the lower half serves CN=0, the upper half CN=1.
    localparam logic [3:0] W_PLA_DATA [32] = '{
        4'hE, 4'h0, 4'hC, 4'h8, 4'h2, 4'hA, 4'hE, 4'h2,
        4'hE, 4'hA, 4'h0, 4'h0, 4'h2, 4'hA, 4'h2, 4'h2,
        4'hB, 4'h9, 4'h7, 4'hF, 4'hD, 4'hE, 4'hE, 4'hB,
        4'hF, 4'hF, 4'h4, 4'h0, 4'hD, 4'hE, 4'h4, 4'h0
    };

    // m' only contributes to bit 0, and only for the CN=0 half of the table.
    function automatic logic [3:0] pla_lookup(
        input logic       cn,
        input logic [3:0] acc,
        input logic       m_prime
    );
        return W_PLA_DATA[{cn, acc}] | {3'b000, ~cn & m_prime};
    endfunction
`endif

endpackage

// File: rtl/w_digit_scanner.sv
// Snapshot-based scanner: streams W_LEN captured W digits to the LCD path, one per clock.
// Latency: first digit the cycle after scan_start, scan_done W_LEN+1 cycles after it.
// Backpressure: none; scan_start while busy is dropped, the stream cannot be stalled.
//
// Ports:
//   clk, reset       - clock, synchronous active-high reset
//   scan_start       - request a scan (honoured only in IDLE)
//   w_src            - flattened live W, captured into the shadow copy on start
//   scan_valid       - scan_index/scan_digit valid
//   scan_index       - digit position being streamed
//   scan_digit       - shadow digit value
//   scan_done        - one-cycle pulse after the last digit
//   scan_busy        - FSM is not IDLE
module w_digit_scanner
    import w_shift_pkg::*;
#(
    parameter int W_LEN = 9,
    parameter int IDX_W = $clog2(W_LEN)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 scan_start,
    input  logic [W_LEN*4-1:0]   w_src,
    output logic                 scan_valid,
    output logic [IDX_W-1:0]     scan_index,
    output logic [3:0]           scan_digit,
    output logic                 scan_done,
    output logic                 scan_busy
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(W_LEN - 1);

    scan_state_t      state_q;
    logic [3:0]       shadow_q [W_LEN];
    logic [IDX_W-1:0] idx_q;
    logic [IDX_W-1:0] idx_nxt;
    logic             valid_q;
    logic [3:0]       digit_q;
    logic             done_q;
    logic             busy_q;

    assign idx_nxt = idx_q + 1'b1;

    // All outputs are registered: the digit for the next index is loaded
    // alongside the index itself, so digit and index always move together.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= SCAN_IDLE;
            idx_q   <= '0;
            valid_q <= 1'b0;
            digit_q <= 4'h0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
            for (int i = 0; i < W_LEN; i++) begin
                shadow_q[i] <= 4'h0;
            end
        end else begin
            case (state_q)
                SCAN_IDLE: begin
                    done_q <= 1'b0;
                    if (scan_start) begin
                        for (int i = 0; i < W_LEN; i++) begin
                            shadow_q[i] <= w_src[4*i +: 4];
                        end
                        idx_q   <= '0;
                        digit_q <= w_src[3:0];
                        valid_q <= 1'b1;
                        busy_q  <= 1'b1;
                        state_q <= SCAN_RUN;
                    end
                end
                SCAN_RUN: begin
                    if (idx_q == LAST_IDX) begin
                        // Index parks on the last digit until IDLE clears it.
                        valid_q <= 1'b0;
                        digit_q <= 4'h0;
                        done_q  <= 1'b1;
                        state_q <= SCAN_DONE;
                    end else begin
                        idx_q   <= idx_nxt;
                        digit_q <= shadow_q[idx_nxt];
                    end
                end
                SCAN_DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    idx_q   <= '0;
                    state_q <= SCAN_IDLE;
                end
                default: begin
                    state_q <= SCAN_IDLE;
                    idx_q   <= '0;
                    valid_q <= 1'b0;
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign scan_valid = valid_q;
    assign scan_index = idx_q;
    assign scan_digit = digit_q;
    assign scan_done  = done_q;
    assign scan_busy  = busy_q;

endmodule

// File: rtl/w_shift_unit.sv
// W'/W digit shifter executing the W-family instructions, plus the LCD digit scanner.
// Latency: commands update w_prime/w_main one cycle after cmd_en; scan timing per w_digit_scanner.
// Backpressure: none; one command accepted every cycle, no busy state.
//
// Build option: W_SHIFT_PLA_EN compiles in the segment PLA so DTW/PDTW load
// PLA digits; without it DTW/PDTW are no-ops (SM510-class cores).
//
// Ports:
//   clk, reset             - clock, synchronous active-high reset
//   cmd_en, cmd            - command strobe and w_cmd_t opcode
//   acc, lcd_cn, m_prime   - accumulator and PLA select/modifier flags
//   scan_start             - start an LCD scan of W
//   w_main, w_prime        - flattened W and W' (digit i at [4i+3:4i])
//   scan_valid/index/digit - streamed digit
//   scan_done, scan_busy   - scan completion pulse and activity flag
module w_shift_unit
    import w_shift_pkg::*;
#(
    parameter int W_LEN = 9,
    parameter int IDX_W = $clog2(W_LEN)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 cmd_en,
    input  logic [2:0]           cmd,
    input  logic [3:0]           acc,
    input  logic                 lcd_cn,
    input  logic                 m_prime,
    input  logic                 scan_start,
    output logic [W_LEN*4-1:0]   w_main,
    output logic [W_LEN*4-1:0]   w_prime,
    output logic                 scan_valid,
    output logic [IDX_W-1:0]     scan_index,
    output logic [3:0]           scan_digit,
    output logic                 scan_done,
    output logic                 scan_busy
);

    logic [3:0] wp_q [W_LEN];
    logic [3:0] wp_d [W_LEN];
    logic [3:0] w_q  [W_LEN];
    logic [3:0] w_d  [W_LEN];

    w_cmd_t     cmd_e;
    logic       shift_en;
    logic [3:0] shift_val;

    assign cmd_e = w_cmd_t'(cmd);

`ifdef W_SHIFT_PLA_EN
    logic [3:0] pla_digit;
    assign pla_digit = pla_lookup(lcd_cn, acc, m_prime);
`else
    // PLA select inputs have no function on PLA-less cores.
    logic unused_pla_inputs;
    assign unused_pla_inputs = ^{lcd_cn, m_prime};
`endif

    // Which value, if any, enters W' at the top digit via a full shift.
    always_comb begin
        shift_en  = 1'b0;
        shift_val = 4'h0;
        if (cmd_en) begin
            case (cmd_e)
                CMD_WR: begin
                    shift_en  = 1'b1;
                    shift_val = acc & 4'h7;
                end
                CMD_WS: begin
                    shift_en  = 1'b1;
                    shift_val = acc | 4'h8;
                end
`ifdef W_SHIFT_PLA_EN
                CMD_DTW: begin
                    shift_en  = 1'b1;
                    shift_val = pla_digit;
                end
`endif
                default: begin
                    shift_en  = 1'b0;
                    shift_val = 4'h0;
                end
            endcase
        end
    end

    always_comb begin
        wp_d = wp_q;
        w_d  = w_q;
        if (shift_en) begin
            // Digits move toward index 0; the new digit lands at the top.
            for (int i = 0; i < W_LEN - 1; i++) begin
                wp_d[i] = wp_q[i+1];
            end
            wp_d[W_LEN-1] = shift_val;
        end else if (cmd_en) begin
            case (cmd_e)
`ifdef W_SHIFT_PLA_EN
                CMD_PDTW: begin
                    wp_d[W_LEN-2] = wp_q[W_LEN-1];
                    wp_d[W_LEN-1] = pla_digit;
                end
`endif
                CMD_PTW: begin
                    w_d[W_LEN-1] = wp_q[W_LEN-1];
                    w_d[W_LEN-2] = wp_q[W_LEN-2];
                end
                CMD_TW: begin
                    w_d = wp_q;
                end
                CMD_CLR: begin
                    for (int i = 0; i < W_LEN; i++) begin
                        wp_d[i] = 4'h0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < W_LEN; i++) begin
                wp_q[i] <= 4'h0;
                w_q[i]  <= 4'h0;
            end
        end else begin
            wp_q <= wp_d;
            w_q  <= w_d;
        end
    end

    for (genvar g = 0; g < W_LEN; g++) begin : g_flat
        assign w_prime[4*g +: 4] = wp_q[g];
        assign w_main[4*g +: 4]  = w_q[g];
    end

    // The scanner samples the registered W, so a TW in the start cycle is
    // not yet visible to the snapshot.
    w_digit_scanner #(
        .W_LEN (W_LEN),
        .IDX_W (IDX_W)
    ) u_scanner (
        .clk        (clk),
        .reset      (reset),
        .scan_start (scan_start),
        .w_src      (w_main),
        .scan_valid (scan_valid),
        .scan_index (scan_index),
        .scan_digit (scan_digit),
        .scan_done  (scan_done),
        .scan_busy  (scan_busy)
    );

endmodule

// File: tb/tb_w_shift_unit.sv
// Bench for w_shift_unit: two instances (W_LEN 9 and 4) on shared stimulus,
// a cycle-level reference model, directed literal checks, then random traffic.
module tb_w_shift_unit;

    logic       clk = 1'b0;
    logic       reset;
    logic       cmd_en;
    logic [2:0] cmd;
    logic [3:0] acc;
    logic       lcd_cn;
    logic       m_prime;
    logic       scan_start;

    logic [35:0] wm9, wp9;
    logic        sv9, sd9, sb9;
    logic [3:0]  si9, sdg9;
    logic [15:0] wm4, wp4;
    logic        sv4, sd4, sb4;
    logic [1:0]  si4;
    logic [3:0]  sdg4;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    w_shift_unit #(.W_LEN(9)) dut9 (
        .clk(clk), .reset(reset), .cmd_en(cmd_en), .cmd(cmd), .acc(acc),
        .lcd_cn(lcd_cn), .m_prime(m_prime), .scan_start(scan_start),
        .w_main(wm9), .w_prime(wp9), .scan_valid(sv9), .scan_index(si9),
        .scan_digit(sdg9), .scan_done(sd9), .scan_busy(sb9)
    );

    w_shift_unit #(.W_LEN(4)) dut4 (
        .clk(clk), .reset(reset), .cmd_en(cmd_en), .cmd(cmd), .acc(acc),
        .lcd_cn(lcd_cn), .m_prime(m_prime), .scan_start(scan_start),
        .w_main(wm4), .w_prime(wp4), .scan_valid(sv4), .scan_index(si4),
        .scan_digit(sdg4), .scan_done(sd4), .scan_busy(sb4)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    localparam logic [3:0] REF_PLA [32] = '{
        4'hE, 4'h0, 4'hC, 4'h8, 4'h2, 4'hA, 4'hE, 4'h2,
        4'hE, 4'hA, 4'h0, 4'h0, 4'h2, 4'hA, 4'h2, 4'h2,
        4'hB, 4'h9, 4'h7, 4'hF, 4'hD, 4'hE, 4'hE, 4'hB,
        4'hF, 4'hF, 4'h4, 4'h0, 4'hD, 4'hE, 4'h4, 4'h0
    };
`ifdef W_SHIFT_PLA_EN
    localparam bit HAS_PLA = 1'b1;
`else
    localparam bit HAS_PLA = 1'b0;
`endif

    int         L [2] = '{9, 4};
    logic [3:0] mwp   [2][16];
    logic [3:0] mw    [2][16];
    logic [3:0] msnap [2][16];
    longint     t0 [2] = '{-1, -1};   // cycle in which the running scan was accepted
    longint     mc = 0;               // number of clock edges seen
    bit         mvalid = 1'b0;

    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            int n;
            logic [3:0] v;
            logic [3:0] pla;
            bit sh;
            n   = L[d];
            sh  = 1'b0;
            v   = 4'h0;
            pla = REF_PLA[{lcd_cn, acc}] | ((!lcd_cn && m_prime) ? 4'h1 : 4'h0);
            if (reset) begin
                for (int i = 0; i < 16; i++) begin
                    mwp[d][i] = 4'h0;
                    mw[d][i]  = 4'h0;
                end
                t0[d] = -1;
            end else begin
                if (scan_start && (t0[d] < 0 || mc >= t0[d] + n + 2)) begin
                    t0[d] = mc;
                    for (int i = 0; i < 16; i++) msnap[d][i] = mw[d][i];
                end
                if (cmd_en) begin
                    case (cmd)
                        3'd1: begin sh = 1'b1; v = acc & 4'h7; end
                        3'd2: begin sh = 1'b1; v = acc | 4'h8; end
                        3'd3: if (HAS_PLA) begin sh = 1'b1; v = pla; end
                        3'd4: if (HAS_PLA) begin
                            mwp[d][n-2] = mwp[d][n-1];
                            mwp[d][n-1] = pla;
                        end
                        3'd5: begin
                            mw[d][n-1] = mwp[d][n-1];
                            mw[d][n-2] = mwp[d][n-2];
                        end
                        3'd6: for (int i = 0; i < n; i++) mw[d][i] = mwp[d][i];
                        3'd7: for (int i = 0; i < n; i++) mwp[d][i] = 4'h0;
                        default: ;
                    endcase
                    if (sh) begin
                        for (int i = 0; i < n - 1; i++) mwp[d][i] = mwp[d][i+1];
                        mwp[d][n-1] = v;
                    end
                end
            end
        end
        if (reset) mvalid = 1'b1;
        mc++;
    end

    function automatic logic [63:0] flat(input int d, input bit main);
        logic [63:0] r;
        r = '0;
        for (int i = 0; i < L[d]; i++) r[4*i +: 4] = main ? mw[d][i] : mwp[d][i];
        return r;
    endfunction

    task automatic cmp(input int d, input logic [63:0] wp, input logic [63:0] w,
                       input logic v, input logic [3:0] ix, input logic [3:0] dg,
                       input logic dn, input logic bsy);
        longint k;
        bit ev, ed, eb;
        string p;
        p  = $sformatf("L%0d", L[d]);
        k  = (t0[d] < 0) ? -1 : (mc - t0[d] - 1);
        ev = (k >= 0) && (k < L[d]);
        ed = (k == L[d]);
        eb = (k >= 0) && (k <= L[d]);
        chk({p, ".w_prime"}, wp, flat(d, 1'b0));
        chk({p, ".w_main"}, w, flat(d, 1'b1));
        chk({p, ".scan_valid"}, 64'(v), 64'(ev));
        chk({p, ".scan_done"}, 64'(dn), 64'(ed));
        chk({p, ".scan_busy"}, 64'(bsy), 64'(eb));
        if (ev) begin
            chk({p, ".scan_index"}, 64'(ix), 64'(k));
            chk({p, ".scan_digit"}, 64'(dg), 64'(msnap[d][k]));
        end else if (!eb) begin
            chk({p, ".idle_index"}, 64'(ix), 64'd0);
        end
    endtask

    // Single compare process: every cycle once the model has seen a reset.
    always @(negedge clk) begin
        if (mvalid) begin
            cmp(0, 64'(wp9), 64'(wm9), sv9, si9, sdg9, sd9, sb9);
            cmp(1, 64'(wp4), 64'(wm4), sv4, {2'b00, si4}, sdg4, sd4, sb4);
        end
    end

    // ---------------- stimulus ----------------
    task automatic step(input logic rst, input logic en, input logic [2:0] c,
                        input logic [3:0] a, input logic cn, input logic m, input logic st);
        reset = rst; cmd_en = en; cmd = c; acc = a; lcd_cn = cn; m_prime = m; scan_start = st;
        @(posedge clk);
        #1;
    endtask

    task automatic op(input logic [2:0] c, input logic [3:0] a);
        step(1'b0, 1'b1, c, a, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        int nv, nd;
        step(1'b1, 1'b0, 3'd0, 4'h0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 3'd2, 4'hF, 1'b0, 1'b0, 1'b1);
        step(1'b1, 1'b0, 3'd0, 4'h0, 1'b0, 1'b0, 1'b0);
        chk("reset.w_prime", 64'(wp9), 64'd0);
        chk("reset.w_main", 64'(wm9), 64'd0);
        chk("reset.scan_busy", 64'(sb9), 64'd0);
        chk("reset.scan_digit", 64'(sdg9), 64'd0);

        // cmd_en low: no change whatever cmd says
        step(1'b0, 1'b0, 3'd2, 4'h5, 1'b0, 1'b0, 1'b0);
        chk("no_en.w_prime", 64'(wp9), 64'd0);

        op(3'd1, 4'hF);
        chk("wr.w_prime9", 64'(wp9), 64'h7_0000_0000);
        chk("wr.w_prime4", 64'(wp4), 64'h7000);
        op(3'd2, 4'h0);
        chk("ws.w_prime9", 64'(wp9), 64'h8_7000_0000);
        chk("ws.w_prime4", 64'(wp4), 64'h8700);

`ifdef W_SHIFT_PLA_EN
        step(1'b0, 1'b1, 3'd3, 4'h0, 1'b0, 1'b1, 1'b0);
        chk("dtw_cn0.top", 64'(wp9[35:32]), 64'hF);
        step(1'b0, 1'b1, 3'd3, 4'h0, 1'b1, 1'b1, 1'b0);
        chk("dtw_cn1.top2", 64'(wp9[35:28]), 64'hBF);
        op(3'd1, 4'h5);
        step(1'b0, 1'b1, 3'd4, 4'h1, 1'b0, 1'b0, 1'b0);
        chk("pdtw4.top2", 64'(wp4[15:8]), 64'h05);
`else
        step(1'b0, 1'b1, 3'd3, 4'h0, 1'b0, 1'b1, 1'b0);
        chk("dtw_nop.w_prime9", 64'(wp9), 64'h8_7000_0000);
        step(1'b0, 1'b1, 3'd4, 4'h1, 1'b0, 1'b0, 1'b0);
        chk("pdtw_nop.w_prime4", 64'(wp4), 64'h8700);
`endif

        // Fill W' with 1..9 (digit 0 = 1)
        op(3'd7, 4'h0);
        chk("clr.w_prime9", 64'(wp9), 64'd0);
        for (int v = 1; v <= 7; v++) op(3'd1, 4'(v));
        op(3'd2, 4'h0);
        op(3'd2, 4'h1);
        chk("fill.w_prime9", 64'(wp9), 64'h9_8765_4321);
        op(3'd5, 4'h0);
        chk("ptw.w_main9", 64'(wm9), 64'h9_8000_0000);
        op(3'd6, 4'h0);
        chk("tw.w_main9", 64'(wm9), 64'h9_8765_4321);

        // Scan with W' changed and TW issued mid-stream
        step(1'b0, 1'b0, 3'd0, 4'h0, 1'b0, 1'b0, 1'b1);
        for (int k = 0; k < 9; k++) begin
            if (k > 0) begin
                if (k == 3)      op(3'd1, 4'h0);
                else if (k == 4) op(3'd6, 4'h0);
                else             op(3'd0, 4'h0);
            end
            chk("scan.valid", 64'(sv9), 64'd1);
            chk("scan.index", 64'(si9), 64'(k));
            chk("scan.digit", 64'(sdg9), 64'(k + 1));
        end
        op(3'd0, 4'h0);
        chk("scan.done", 64'(sd9), 64'd1);
        op(3'd0, 4'h0);
        chk("scan.idle_busy", 64'(sb9), 64'd0);
        chk("scan.done_clear", 64'(sd9), 64'd0);

        // Repeated scan_start while busy is ignored
        nv = 0; nd = 0;
        for (int c = 0; c < 13; c++) begin
            step(1'b0, 1'b0, 3'd0, 4'h0, 1'b0, 1'b0, (c < 10) ? 1'b1 : 1'b0);
            nv += int'(sv9);
            nd += int'(sd9);
        end
        chk("repeat.valids", 64'(nv), 64'd9);
        chk("repeat.dones", 64'(nd), 64'd1);

        // Reset while the fourth digit is on the bus
        op(3'd0, 4'h0);
        op(3'd0, 4'h0);
        step(1'b0, 1'b0, 3'd0, 4'h0, 1'b0, 1'b0, 1'b1);
        op(3'd0, 4'h0);
        op(3'd0, 4'h0);
        op(3'd0, 4'h0);
        chk("midreset.index_before", 64'(si9), 64'd3);
        step(1'b1, 1'b0, 3'd0, 4'h0, 1'b0, 1'b0, 1'b0);
        chk("midreset.busy", 64'(sb9), 64'd0);
        chk("midreset.valid", 64'(sv9), 64'd0);
        chk("midreset.index", 64'(si9), 64'd0);
        nd = 0;
        for (int c = 0; c < 12; c++) begin
            op(3'd0, 4'h0);
            nd += int'(sd9);
        end
        chk("midreset.no_done", 64'(nd), 64'd0);

        // Randomized traffic against the model
        for (int c = 0; c < 3000; c++) begin
            step(($urandom_range(0, 199) == 0) ? 1'b1 : 1'b0,
                 ($urandom_range(0, 9) < 7) ? 1'b1 : 1'b0,
                 3'($urandom_range(0, 7)),
                 4'($urandom_range(0, 15)),
                 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 9) == 0) ? 1'b1 : 1'b0);
        end

        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
